// File: rtl/round_share_pkg.sv
// Shared defaults and helpers for the round-robin shared multiply/round pipeline.
package round_share_pkg;

    localparam int unsigned NReqDef     = 4;
    localparam int unsigned WidthInDef  = 4;
    localparam int unsigned WidthOutDef = 4;
    localparam int unsigned IdWDef      = $clog2(NReqDef);

    // Requester index for the default configuration.
    typedef logic [IdWDef-1:0] id_t;

    localparam logic [15:0] SatCountMax = 16'hFFFF;

    // Largest positive code of a signed width-bit result; the negative limit is its negation.
    function automatic int sat_max(int unsigned width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/round_sat_stage.sv
// Combinational round-half-up and symmetric saturation of a Q2.(2*WIDTH_IN-2) product
// down to a Q1.(WIDTH_OUT-1) result.
module round_sat_stage
    import round_share_pkg::*;
#(
    parameter int unsigned WIDTH_IN  = WidthInDef,
    parameter int unsigned WIDTH_OUT = WidthOutDef
) (
    input  logic [2*WIDTH_IN-1:0] prod_i,
    output logic [WIDTH_OUT-1:0]  data_o,
    output logic                  sat_o
);

    localparam int unsigned WP = 2 * WIDTH_IN;
    localparam int unsigned WS = WIDTH_OUT + 2;

    localparam logic signed [WS-1:0] SatHi = WS'(sat_max(WIDTH_OUT));
    localparam logic signed [WS-1:0] SatLo = -SatHi;

    logic [WIDTH_OUT-1:0] kept;
    logic                 rnd_bit;
    logic signed [WS-1:0] sum;

    // Round, then clamp into the symmetric range.
    always_comb begin
        kept    = prod_i[WP-2 -: WIDTH_OUT];
        rnd_bit = prod_i[WP-2-WIDTH_OUT];
        // Extend with the true product sign so the lone +1.0 product (-1 * -1) reads as
        // an overflow instead of wrapping to the most negative code.
        sum     = $signed({prod_i[WP-1], prod_i[WP-1], kept})
                + $signed({{(WS-1){1'b0}}, rnd_bit});
        data_o  = sum[WIDTH_OUT-1:0];
        sat_o   = 1'b0;
        if (sum > SatHi) begin
            data_o = SatHi[WIDTH_OUT-1:0];
            sat_o  = 1'b1;
        end else if (sum < SatLo) begin
            data_o = SatLo[WIDTH_OUT-1:0];
            sat_o  = 1'b1;
        end
    end

    // Bits below the round position do not affect the result.
    if (WP - 2 > WIDTH_OUT) begin : g_low
        logic unused_low;
        assign unused_low = ^prod_i[WP-3-WIDTH_OUT:0];
    end

endmodule

// File: rtl/round_share_arbiter.sv
// Round-robin arbiter feeding a shared 2-stage signed multiply + round/saturate pipeline.
// Results carry the index of the requester that produced them.
// Optional feature: define SAT_STATS_EN to build the saturating 16-bit clamp-event counter;
// otherwise sat_count is tied to zero.
module round_share_arbiter
    import round_share_pkg::*;
#(
    parameter int unsigned N_REQ     = NReqDef,
    parameter int unsigned WIDTH_IN  = WidthInDef,
    parameter int unsigned WIDTH_OUT = WidthOutDef
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*WIDTH_IN-1:0]   req_a,
    input  logic [N_REQ*WIDTH_IN-1:0]   req_b,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH_OUT-1:0]        out_data,
    output logic [$clog2(N_REQ)-1:0]    out_id,
    output logic                        out_sat,
    output logic [15:0]                 sat_count
);

    localparam int unsigned IdW = $clog2(N_REQ);
    localparam int unsigned WP  = 2 * WIDTH_IN;

    logic signed [WIDTH_IN-1:0] a_arr [N_REQ];
    logic signed [WIDTH_IN-1:0] b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH_IN +: WIDTH_IN];
        assign b_arr[g] = req_b[g*WIDTH_IN +: WIDTH_IN];
    end

    logic [IdW-1:0]       ptr_q, ptr_d;
    logic                 s1_valid_q, s1_valid_d;
    logic signed [WP-1:0] s1_prod_q, s1_prod_d;
    logic [IdW-1:0]       s1_id_q, s1_id_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH_OUT-1:0] out_data_q, out_data_d;
    logic [IdW-1:0]       out_id_q, out_id_d;
    logic                 out_sat_q, out_sat_d;

    logic                 advance;
    logic                 gnt_any;
    logic [IdW-1:0]       gnt_idx;
    logic [N_REQ-1:0]     grant;
    int unsigned          cand;
    logic [IdW-1:0]       cand_idx;

    logic [WIDTH_OUT-1:0] rs_data;
    logic                 rs_sat;

    // Round-robin grant: first valid requester at or after the pointer, only while moving.
    always_comb begin
        advance  = !out_valid_q || out_ready;
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        if (advance) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cand = 32'(ptr_q) + i;
                if (cand >= N_REQ) begin
                    cand = cand - N_REQ;
                end
                cand_idx = IdW'(cand);
                if (!gnt_any && req_valid[cand_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand_idx;
                end
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = grant;

    round_sat_stage #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT)
    ) u_round_sat (
        .prod_i (s1_prod_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    // Next state for pointer and both pipeline stages; everything holds under stall.
    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_prod_d   = s1_prod_q;
        s1_id_d     = s1_id_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_sat_d   = out_sat_q;
        // A grant is always a transfer because it is only issued to a valid requester.
        if (gnt_any) begin
            ptr_d = (gnt_idx == IdW'(N_REQ - 1)) ? '0 : gnt_idx + IdW'(1);
        end
        if (advance) begin
            s1_valid_d  = gnt_any;
            s1_prod_d   = WP'(a_arr[gnt_idx]) * WP'(b_arr[gnt_idx]);
            s1_id_d     = gnt_idx;
            out_valid_d = s1_valid_q;
            out_data_d  = rs_data;
            out_id_d    = s1_id_q;
            out_sat_d   = rs_sat;
        end
    end

    // Pipeline and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_id_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_id_q     <= s1_id_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_sat   = out_sat_q;

`ifdef SAT_STATS_EN
    logic [15:0] sat_count_q, sat_count_d;

    // Count clamped results as they leave; sticks at all-ones.
    always_comb begin
        sat_count_d = sat_count_q;
        if (out_valid_q && out_ready && out_sat_q && (sat_count_q != SatCountMax)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count_q <= 16'h0000;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`else
    assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_round_share_arbiter.sv
// Directed self-checking bench for round_share_arbiter (N_REQ=4, WIDTH_IN=4, WIDTH_OUT=4).
module tb_round_share_arbiter;

`ifdef SAT_STATS_EN
    localparam int SatStats = 1;
`else
    localparam int SatStats = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_id;
    logic        out_sat;
    logic [15:0] sat_count;

    int n_cmp = 0;
    int n_err = 0;

    round_share_arbiter #(
        .N_REQ     (4),
        .WIDTH_IN  (4),
        .WIDTH_OUT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_sat   (out_sat),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One isolated transfer from requester idx; result expected two edges after acceptance.
    task automatic send(input int idx, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_d, input logic exp_s);
        @(negedge clk);
        req_valid          = '0;
        req_valid[idx]     = 1'b1;
        req_a[idx*4 +: 4]  = a;
        req_b[idx*4 +: 4]  = b;
        #1;
        check("single.ready", 32'(req_ready), 32'(1) << idx);
        @(posedge clk);
        #1;
        req_valid = '0;
        check("single.lat1", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("single.valid", 32'(out_valid), 1);
        check("single.data", 32'(out_data), 32'(exp_d));
        check("single.id", 32'(out_id), idx);
        check("single.sat", 32'(out_sat), 32'(exp_s));
        @(posedge clk);
        #1;
        check("single.drain", 32'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 32'(out_valid), 0);
        check("rst.data", 32'(out_data), 0);
        check("rst.id", 32'(out_id), 0);
        check("rst.sat", 32'(out_sat), 0);
        check("rst.cnt", 32'(sat_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Rounding / saturation vectors (negative operands as 4-bit two's complement).
        send(0, 4'd6, 4'd5, 4'h4, 1'b0);   //  30/64 -> 0.5
        send(0, 4'h8, 4'h8, 4'h7, 1'b1);   // +1.0 clamps to max
        send(0, 4'hF, 4'h1, 4'h0, 1'b0);   // -1/64 rounds up to 0
        send(0, 4'h8, 4'h1, 4'hF, 1'b0);   // -8/64 -> -1/8
        send(0, 4'h8, 4'h7, 4'h9, 1'b0);   // -56/64 -> -7/8
        send(1, 4'd7, 4'd7, 4'h6, 1'b0);   //  49/64 -> 6/8
        send(2, 4'd3, 4'd3, 4'h1, 1'b0);   //   9/64 -> 1/8
        send(3, 4'h9, 4'd5, 4'hC, 1'b0);   // -35/64 -> -4/8 (half up)
        check("cnt.after_singles", 32'(sat_count), SatStats);

        // All requesters busy: grants rotate 0..3; requester i yields data i+1.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_a[i*4 +: 4] = 4'(i + 1);
            req_b[i*4 +: 4] = 4'd7;
        end
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            check("rr.ready", 32'(req_ready), 32'(1) << (k % 4));
            if (k >= 2) begin
                check("rr.valid", 32'(out_valid), 1);
                check("rr.id", 32'(out_id), (k - 2) % 4);
                check("rr.data", 32'(out_data), ((k - 2) % 4) + 1);
            end
        end

        // Three stalled cycles with the pipe full.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            check("stall.ready", 32'(req_ready), 0);
            check("stall.valid", 32'(out_valid), 1);
            check("stall.id", 32'(out_id), 2);
            check("stall.data", 32'(out_data), 3);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("rel.ready0", 32'(req_ready), 32'h1);
        check("rel.id_held", 32'(out_id), 2);
        @(negedge clk);
        check("rel.ready1", 32'(req_ready), 32'h2);
        check("rel.id3", 32'(out_id), 3);
        check("rel.data4", 32'(out_data), 4);
        @(negedge clk);
        check("rel.ready2", 32'(req_ready), 32'h4);
        check("rel.id0", 32'(out_id), 0);
        check("rel.data1", 32'(out_data), 1);
        req_valid = '0;
        @(negedge clk);
        check("rel.id1", 32'(out_id), 1);
        check("rel.data2", 32'(out_data), 2);
        check("rel.valid1", 32'(out_valid), 1);
        @(negedge clk);
        check("bubble.valid", 32'(out_valid), 0);

        // Reset with two products in flight: they must never appear.
        req_valid = 4'hF;
        #1;
        check("mid.ready2", 32'(req_ready), 32'h4);
        @(negedge clk);
        check("mid.ready3", 32'(req_ready), 32'h8);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        check("mid.valid", 32'(out_valid), 0);
        check("mid.data", 32'(out_data), 0);
        check("mid.id", 32'(out_id), 0);
        check("mid.sat", 32'(out_sat), 0);
        check("mid.cnt", 32'(sat_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid.discard", 32'(out_valid), 0);
        end
        req_valid = 4'hF;
        #1;
        check("mid.ptr0", 32'(req_ready), 32'h1);
        req_valid = '0;

        // Saturating transfers, the first one held for two stalled edges.
        req_valid[0] = 1'b1;
        req_a[3:0]   = 4'h8;
        req_b[3:0]   = 4'h8;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        check("sat.valid", 32'(out_valid), 1);
        check("sat.flag", 32'(out_sat), 1);
        check("sat.data", 32'(out_data), 7);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sat.stall_valid", 32'(out_valid), 1);
        check("sat.stall_cnt", 32'(sat_count), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("sat.cnt1", 32'(sat_count), SatStats);
        check("sat.gone", 32'(out_valid), 0);
        send(0, 4'h8, 4'h8, 4'h7, 1'b1);
        send(0, 4'h8, 4'h8, 4'h7, 1'b1);
        check("sat.cnt3", 32'(sat_count), 3 * SatStats);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
